dmem_ctrl: RTL and testbench

Second-generation data memory for the RV32I core: byte-addressed, byte-lane-correct loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW at any legal offset), behind a valid/ready request/response handshake. Programmable access latency models slower memory. Flags misaligned and illegal accesses instead of silently corrupting data. Sits between the execute/memory stage and the data RAM; the core stalls on req_ready/rsp_valid.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_bytelane_ram.sv | 23 ++
 rtl/dmem_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the RV32I data-memory controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  // Pick the addressed lane out of a RAM word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      F3_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

  // Byte enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_lanes(input logic [1:0] offset,
                                             input logic [2:0] funct3);
    case (funct3)
      F3_B:    return 4'b0001 << offset;
      F3_H:    return offset[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-organised data RAM with per-byte write enables and registered read.
module dmem_bytelane_ram #(
  parameter int unsigned WORD_AW = 9
) (
  input  logic               clk,
  input  logic [WORD_AW-1:0] addr,
  input  logic [3:0]         be,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  localparam int unsigned DEPTH = 1 << WORD_AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory controller with valid/ready handshake and fixed access latency.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses; otherwise low address bits are ignored.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned WORD_AW  = ADDR_W - 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam dmem_state_t AFTER_ACCEPT = (WAIT_CYCLES == 0) ? ACCESS : WAIT;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_ctrl: WAIT_CYCLES must be 0..15");
  end

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [1:0]         off_c;
  logic               illegal_c;
  logic               misal_c;
  logic               err_c;
  logic [WORD_AW-1:0] ram_addr_c;
  logic [3:0]         ram_be_c;
  logic [31:0]        ram_wdata_c;
  logic [31:0]        ram_rdata;

  // Request classification and effective lane offset from the captured request.
  always_comb begin
    illegal_c = we_q ? (f3_q > 3'b010)
                     : (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111);
`ifdef DMEM_ALIGN_CHECK_EN
    misal_c = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
              (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    off_c   = addr_q[1:0];
`else
    misal_c = 1'b0;
    case (f3_q[1:0])
      2'b01:   off_c = {addr_q[1], 1'b0};
      2'b10:   off_c = 2'b00;
      default: off_c = addr_q[1:0];
    endcase
`endif
    err_c = illegal_c || misal_c;
  end

  // The read address tracks the incoming request while idle, so data is ready in ACCESS.
  always_comb begin
    ram_addr_c = (state == IDLE) ? req_addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    ram_be_c   = 4'b0000;
    if (state == ACCESS && we_q && !err_c && !rst) ram_be_c = store_lanes(off_c, f3_q);
    case (f3_q[1:0])
      2'b00:   ram_wdata_c = {4{wdata_q[7:0]}};
      2'b01:   ram_wdata_c = {2{wdata_q[15:0]}};
      default: ram_wdata_c = wdata_q;
    endcase
  end

  dmem_bytelane_ram #(
    .WORD_AW (WORD_AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr_c),
    .be    (ram_be_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // Captured request payload; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && req_ready) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= 32'(req_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= AFTER_ACCEPT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_c;
          rsp_rdata <= (err_c || we_q) ? '0 : DATA_W'(load_extend(ram_rdata, off_c, f3_q));
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, backpressure/reset sequences, random traffic vs byte-array model.
module tb_dmem_ctrl;

  localparam int unsigned W = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [10:0] req_addr = 11'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_ctrl #(.ADDR_W(11), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem_m [128];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [10:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [10:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.er = er;
    vt.push_back(v);
  endtask

  // Reference: byte-addressed memory, sizes and extension straight from the ISA rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [10:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size, base;
    bit illegal, mis;
    logic [31:0] v;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis     = (int'(a) % size) != 0;
`ifdef DMEM_ALIGN_CHECK_EN
    er = illegal || mis;
`else
    er = illegal;
`endif
    base = int'(a) - (int'(a) % size);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[base + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[base + i];
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // One full request/response with rsp_ready high; entered and left at posedge+1.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [10:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(W + 1));
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, mrd, prior;
    logic        er, mer;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(rsp_err), 32'd0);

    // Fill the test region so later loads never see uninitialised RAM.
    for (int w = 0; w < 32; w++) begin
      logic [31:0] d;
      d = $urandom;
      model(1'b1, 3'b010, 11'(w * 4), d, mrd, mer);
      xact(1'b1, 3'b010, 11'(w * 4), d, rd, er);
      chk("init err", 32'(er), 32'(mer));
    end

    add(1, 3'b010, 11'h010, 32'hDEADBEEF, 32'h0,        0);
    add(0, 3'b010, 11'h010, 32'h0,        32'hDEADBEEF, 0);
    add(1, 3'b000, 11'h013, 32'h0000005A, 32'h0,        0);
    add(0, 3'b010, 11'h010, 32'h0,        32'h5AADBEEF, 0);
    add(0, 3'b000, 11'h013, 32'h0,        32'h0000005A, 0);
    add(0, 3'b000, 11'h012, 32'h0,        32'hFFFFFFAD, 0);
    add(0, 3'b100, 11'h012, 32'h0,        32'h000000AD, 0);
    add(1, 3'b010, 11'h020, 32'hCAFE7123, 32'h0,        0);
    add(1, 3'b001, 11'h022, 32'h00008001, 32'h0,        0);
    add(0, 3'b001, 11'h022, 32'h0,        32'hFFFF8001, 0);
    add(0, 3'b101, 11'h022, 32'h0,        32'h00008001, 0);
    add(0, 3'b001, 11'h020, 32'h0,        32'h00007123, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    add(0, 3'b010, 11'h011, 32'h0,        32'h0,        1);
    add(1, 3'b001, 11'h021, 32'h0000BEEF, 32'h0,        1);
    add(0, 3'b010, 11'h020, 32'h0,        32'h80017123, 0);
    add(0, 3'b101, 11'h013, 32'h0,        32'h0,        1);
`else
    add(0, 3'b010, 11'h011, 32'h0,        32'h5AADBEEF, 0);
    add(1, 3'b001, 11'h021, 32'h0000BEEF, 32'h0,        0);
    add(0, 3'b010, 11'h020, 32'h0,        32'h8001BEEF, 0);
    add(0, 3'b101, 11'h013, 32'h0,        32'h00005AAD, 0);
`endif
    add(0, 3'b011, 11'h010, 32'h0,        32'h0,        1);
    add(1, 3'b011, 11'h010, 32'h11111111, 32'h0,        1);
    add(0, 3'b010, 11'h010, 32'h0,        32'h5AADBEEF, 0);

    foreach (vt[i]) begin
      xact(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, rd, er);
      chk($sformatf("vec%0d rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].er));
      model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, mrd, mer);
    end

    // Backpressure: response must hold while the consumer stalls.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 11'h010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 40 && !rsp_valid; n++) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_rdata", rsp_rdata, 32'h5AADBEEF);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release req_ready", 32'(req_ready), 32'd1);
    chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset while a store waits: the store must be dropped.
    model(1'b0, 3'b010, 11'h040, 32'h0, prior, mer);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 11'h040;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst no rsp_valid", 32'(rsp_valid), 32'd0);
    xact(1'b0, 3'b010, 11'h040, 32'h0, rd, er);
    chk("rst store dropped", rd, prior);

    // Random traffic against the model.
    for (int t = 0; t < 150; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [10:0] a;
      logic [31:0] wd;
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      a  = 11'($urandom % 128);
      wd = $urandom;
      model(we, f3, a, wd, mrd, mer);
      xact(we, f3, a, wd, rd, er);
      chk($sformatf("rnd%0d rdata we=%0d f3=%0d a=%03h", t, we, f3, a), rd, mrd);
      chk($sformatf("rnd%0d err", t), 32'(er), 32'(mer));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
